// File: rtl/scan_index_sequencer_if.sv
// rtl/scan_index_sequencer_if.sv - control/status bundle between a scan controller and the index sequencer
interface scan_index_sequencer_if #(
    parameter int DWELL_W = 8
);
    logic               start;
    logic               stop;
    logic               oneShot;
    logic [15:0]        chanMask;
    logic [DWELL_W-1:0] dwellCycles;
    logic [3:0]         index;
    logic               indexValid;
    logic               busy;
    logic               scanDone;

    // Controller side: issues scan commands, observes the selection
    modport master (
        output start,
        output stop,
        output oneShot,
        output chanMask,
        output dwellCycles,
        input  index,
        input  indexValid,
        input  busy,
        input  scanDone
    );

    // Sequencer side
    modport slave (
        input  start,
        input  stop,
        input  oneShot,
        input  chanMask,
        input  dwellCycles,
        output index,
        output indexValid,
        output busy,
        output scanDone
    );
endinterface

// File: rtl/scan_index_sequencer.sv
// rtl/scan_index_sequencer.sv - steps a 4-bit decoder select through the set bits of a channel mask
module scan_index_sequencer #(
    parameter int DWELL_W = 8
) (
    input  logic                 clk,
    input  logic                 rstN,
    scan_index_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEEK  = 2'd1,
        DWELL = 2'd2
    } state_t;

    state_t             state;
    logic [3:0]         index_q;
    logic               valid_q;
    logic               done_q;
    logic [3:0]         ptr_q;
    logic [DWELL_W-1:0] cnt_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [15:0]        mask_q;
    logic               one_shot_q;

    logic [15:0]        seek_bits;
    logic [3:0]         seek_pos;
    logic [15:0]        above_bits;
    logic               has_above;

    // Lowest latched channel at or above the search pointer, and whether any channel lies above the current one
    always_comb begin
        seek_bits  = mask_q & (16'hFFFF << ptr_q);
        seek_pos   = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (seek_bits[i]) begin
                seek_pos = 4'(i);
            end
        end
        above_bits = mask_q & (16'hFFFE << index_q);
        has_above  = |above_bits;
    end

    // Scan FSM; every output except busy is a register so the decoder select never glitches
    always_ff @(posedge clk) begin
        if (!rstN) begin
            state      <= IDLE;
            index_q    <= 4'd0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            ptr_q      <= 4'd0;
            cnt_q      <= '0;
            dwell_q    <= '0;
            mask_q     <= 16'd0;
            one_shot_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    valid_q <= 1'b0;
                    // stop takes priority so a simultaneous start/stop is a no-op
                    if (!bus.stop && bus.start) begin
                        if (bus.chanMask != 16'd0) begin
                            mask_q     <= bus.chanMask;
                            dwell_q    <= bus.dwellCycles;
                            one_shot_q <= bus.oneShot;
                            ptr_q      <= 4'd0;
                            state      <= SEEK;
                        end else begin
                            // Nothing to visit: report an immediately finished pass
                            done_q <= 1'b1;
                        end
                    end
                end

                SEEK: begin
                    if (bus.stop) begin
                        valid_q <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        index_q <= seek_pos;
                        valid_q <= 1'b1;
                        cnt_q   <= '0;
                        state   <= DWELL;
                    end
                end

                DWELL: begin
                    if (bus.stop) begin
                        valid_q <= 1'b0;
                        state   <= IDLE;
                    end else if (cnt_q == dwell_q) begin
                        // Every exit from DWELL drops valid for at least one cycle (break-before-make)
                        valid_q <= 1'b0;
                        if (has_above) begin
                            ptr_q <= index_q + 4'd1;
                            state <= SEEK;
                        end else if (one_shot_q) begin
                            done_q <= 1'b1;
                            state  <= IDLE;
                        end else begin
                            done_q <= 1'b1;
                            ptr_q  <= 4'd0;
                            state  <= SEEK;
                        end
                    end else begin
                        // Counter stops at dwell_q, so a full-scale dwell never wraps
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                default: begin
                    valid_q <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.index      = index_q;
    assign bus.indexValid = valid_q;
    assign bus.scanDone   = done_q;
    assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_scan_index_sequencer.sv
// tb/tb_scan_index_sequencer.sv - scoreboard bench for scan_index_sequencer
module tb_scan_index_sequencer;

    localparam int DWELL_W = 8;

    logic clk;
    logic rstN;

    scan_index_sequencer_if #(.DWELL_W(DWELL_W)) bus ();

    scan_index_sequencer #(.DWELL_W(DWELL_W)) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus.slave)
    );

    // Expected {index, indexValid, busy, scanDone} per cycle
    logic [6:0] exp_q[$];
    logic [6:0] exp_v;
    logic [6:0] act_v;
    int         n_assert;
    int         n_fail;
    logic [3:0] model_idx;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got running want finished");
        $fatal(1, "watchdog");
    end

    task automatic push_exp(input logic [3:0] idx, input logic v, input logic b, input logic d);
        exp_q.push_back({idx, v, b, d});
    endtask

    // One pass over the mask as the timing rules describe it: dwell+1 valid cycles per channel, then a gap
    task automatic plan_pass(input logic [15:0] m, input int dw, input bit last_to_idle);
        int last_bit;
        last_bit = -1;
        for (int b = 0; b < 16; b++) begin
            if (m[b]) last_bit = b;
        end
        for (int b = 0; b < 16; b++) begin
            if (m[b]) begin
                for (int c = 0; c <= dw; c++) push_exp(4'(b), 1'b1, 1'b1, 1'b0);
                if (b != last_bit)      push_exp(4'(b), 1'b0, 1'b1, 1'b0);
                else if (last_to_idle)  push_exp(4'(b), 1'b0, 1'b0, 1'b1);
                else                    push_exp(4'(b), 1'b0, 1'b1, 1'b1);
            end
        end
        model_idx = 4'(last_bit);
    endtask

    task automatic test_reset();
        int k;
        rstN = 1'b0;
        bus.start = 1'b1;
        bus.stop = 1'b0;
        bus.oneShot = 1'b1;
        bus.chanMask = 16'h0005;
        bus.dwellCycles = 8'd2;
        for (int i = 0; i < 4; i++) push_exp(4'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        k = 0;
        while (exp_q.size() != 0) begin
            exp_v = exp_q.pop_front();
            act_v = {bus.index, bus.indexValid, bus.busy, bus.scanDone};
            n_assert++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL reset step %0d: got %b want %b (index,valid,busy,done)", k, act_v, exp_v);
            end
            if (k == 2) begin
                rstN = 1'b1;
                bus.start = 1'b0;
            end
            k++;
            @(negedge clk);
        end
        model_idx = 4'd0;
    endtask

    task automatic test_one_shot();
        int k;
        bus.chanMask = 16'h0005;
        bus.dwellCycles = 8'd2;
        bus.oneShot = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        push_exp(model_idx, 1'b0, 1'b1, 1'b0);
        plan_pass(16'h0005, 2, 1'b1);
        push_exp(4'd2, 1'b0, 1'b0, 1'b0);
        k = 0;
        while (exp_q.size() != 0) begin
            exp_v = exp_q.pop_front();
            act_v = {bus.index, bus.indexValid, bus.busy, bus.scanDone};
            n_assert++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL one_shot step %0d: got %b want %b (index,valid,busy,done)", k, act_v, exp_v);
            end
            k++;
            @(negedge clk);
        end
    endtask

    task automatic test_continuous_wrap();
        int k;
        int stop_at;
        bus.chanMask = 16'h8001;
        bus.dwellCycles = 8'd0;
        bus.oneShot = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        push_exp(model_idx, 1'b0, 1'b1, 1'b0);
        for (int p = 0; p < 3; p++) plan_pass(16'h8001, 0, 1'b0);
        stop_at = exp_q.size() - 1;
        push_exp(4'd15, 1'b0, 1'b0, 1'b0);
        model_idx = 4'd15;
        k = 0;
        while (exp_q.size() != 0) begin
            exp_v = exp_q.pop_front();
            act_v = {bus.index, bus.indexValid, bus.busy, bus.scanDone};
            n_assert++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL continuous_wrap step %0d: got %b want %b (index,valid,busy,done)", k, act_v, exp_v);
            end
            bus.stop = (k == stop_at);
            k++;
            @(negedge clk);
        end
        bus.stop = 1'b0;
    endtask

    task automatic test_stop_restart();
        int k;
        int stop_at;
        bus.chanMask = 16'hFFFF;
        bus.dwellCycles = 8'd5;
        bus.oneShot = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        push_exp(model_idx, 1'b0, 1'b1, 1'b0);
        for (int b = 0; b < 4; b++) begin
            for (int c = 0; c < 6; c++) push_exp(4'(b), 1'b1, 1'b1, 1'b0);
            push_exp(4'(b), 1'b0, 1'b1, 1'b0);
        end
        for (int c = 0; c < 3; c++) push_exp(4'd4, 1'b1, 1'b1, 1'b0);
        stop_at = exp_q.size() - 1;
        push_exp(4'd4, 1'b0, 1'b0, 1'b0);
        push_exp(4'd4, 1'b0, 1'b0, 1'b0);
        k = 0;
        while (exp_q.size() != 0) begin
            exp_v = exp_q.pop_front();
            act_v = {bus.index, bus.indexValid, bus.busy, bus.scanDone};
            n_assert++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL stop_mid_dwell step %0d: got %b want %b (index,valid,busy,done)", k, act_v, exp_v);
            end
            bus.stop = (k == stop_at);
            k++;
            @(negedge clk);
        end
        bus.stop = 1'b0;

        bus.dwellCycles = 8'd0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        push_exp(4'd4, 1'b0, 1'b1, 1'b0);
        push_exp(4'd0, 1'b1, 1'b1, 1'b0);
        push_exp(4'd0, 1'b0, 1'b1, 1'b0);
        push_exp(4'd1, 1'b1, 1'b1, 1'b0);
        stop_at = exp_q.size() - 1;
        push_exp(4'd1, 1'b0, 1'b0, 1'b0);
        model_idx = 4'd1;
        k = 0;
        while (exp_q.size() != 0) begin
            exp_v = exp_q.pop_front();
            act_v = {bus.index, bus.indexValid, bus.busy, bus.scanDone};
            n_assert++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL restart step %0d: got %b want %b (index,valid,busy,done)", k, act_v, exp_v);
            end
            bus.stop = (k == stop_at);
            k++;
            @(negedge clk);
        end
        bus.stop = 1'b0;
    endtask

    task automatic test_empty_and_ignored();
        int k;
        int done_k;
        bus.chanMask = 16'h0000;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        push_exp(model_idx, 1'b0, 1'b0, 1'b1);
        push_exp(model_idx, 1'b0, 1'b0, 1'b0);
        k = 0;
        while (exp_q.size() != 0) begin
            exp_v = exp_q.pop_front();
            act_v = {bus.index, bus.indexValid, bus.busy, bus.scanDone};
            n_assert++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL empty_mask step %0d: got %b want %b (index,valid,busy,done)", k, act_v, exp_v);
            end
            k++;
            @(negedge clk);
        end

        bus.chanMask = 16'h0003;
        bus.dwellCycles = 8'd1;
        bus.oneShot = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        push_exp(model_idx, 1'b0, 1'b1, 1'b0);
        plan_pass(16'h0003, 1, 1'b1);
        done_k = exp_q.size() - 1;
        push_exp(4'd1, 1'b0, 1'b0, 1'b0);
        k = 0;
        while (exp_q.size() != 0) begin
            exp_v = exp_q.pop_front();
            act_v = {bus.index, bus.indexValid, bus.busy, bus.scanDone};
            n_assert++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL ignored_inputs step %0d: got %b want %b (index,valid,busy,done)", k, act_v, exp_v);
            end
            bus.start = (k < done_k);
            bus.chanMask = 16'hFFFF;
            bus.dwellCycles = 8'd7;
            bus.oneShot = 1'b0;
            k++;
            @(negedge clk);
        end
        bus.start = 1'b0;
    endtask

    task automatic test_max_dwell();
        int k;
        bus.chanMask = 16'h0010;
        bus.dwellCycles = 8'd255;
        bus.oneShot = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        push_exp(model_idx, 1'b0, 1'b1, 1'b0);
        plan_pass(16'h0010, 255, 1'b1);
        push_exp(4'd4, 1'b0, 1'b0, 1'b0);
        k = 0;
        while (exp_q.size() != 0) begin
            exp_v = exp_q.pop_front();
            act_v = {bus.index, bus.indexValid, bus.busy, bus.scanDone};
            n_assert++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL max_dwell step %0d: got %b want %b (index,valid,busy,done)", k, act_v, exp_v);
            end
            k++;
            @(negedge clk);
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail = 0;
        model_idx = 4'd0;
        test_reset();
        test_one_shot();
        test_continuous_wrap();
        test_stop_restart();
        test_empty_and_ignored();
        test_max_dwell();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/scan_index_sequencer.md
Name: scan_index_sequencer

Overview:
- Generates the 4-bit channel index that drives the 4-to-16 one-hot decoder directly downstream.
- Steps through the set bits of a 16-bit channel mask in ascending order, holding each channel for a programmable dwell time.
- Drops indexValid for one cycle between channels (break-before-make), so the decoded select can be gated without overlap.
- Supports one-shot and continuous scan modes, with start/stop control and a pass-complete pulse.

Parameters:
- DWELL_W, 8, width of the dwell counter; each channel is held dwellCycles+1 cycles.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rstN  input  1  reset; synchronous, active-low.
- start  input  1  begin a scan; sampled only in IDLE.
- stop  input  1  abort the scan; synchronous.
- oneShot  input  1  1 = single pass then IDLE; 0 = wrap continuously. Latched on start.
- chanMask  input  16  channels to visit. Latched on start.
- dwellCycles  input  DWELL_W  hold time minus one. Latched on start.
- index  output  4  current channel number; feeds the decoder's 4-bit select input.
- indexValid  output  1  index is a live selection.
- busy  output  1  state != IDLE.
- scanDone  output  1  one-cycle pulse marking the end of a pass.

Behaviour:
- Reset (rstN=0 at a clock edge): state=IDLE, index=0, indexValid=0, scanDone=0, dwell counter=0, latched mask=0. Reset overrides everything, mid-scan included.
- All outputs are registered. busy is decoded from the state register.
- States are IDLE, SEEK and DWELL.

IDLE:
- start=1 with chanMask!=0: latch mask/dwell/oneShot, set search pointer=0, go to SEEK.
- start=1 with chanMask==0: stay in IDLE and pulse scanDone for one cycle (empty scan).
- index holds its last value; indexValid=0.

SEEK (always exactly one cycle, indexValid=0):
- Find the lowest set latched-mask bit at position >= pointer.
- On the exit edge: index<=found position, indexValid<=1, dwell counter<=0, go to DWELL.
- The pointer is always chosen so that a set bit exists.

DWELL:
- Counter increments every cycle.
- When counter==latched dwell (checked at the clock edge):
  - Set bit exists above index: pointer<=index+1; go to SEEK; indexValid<=0.
  - No set bit above index and oneShot=1: go to IDLE; indexValid<=0; scanDone<=1.
  - No set bit above index and oneShot=0: pointer<=0; go to SEEK; indexValid<=0; scanDone<=1 (pulse coincides with the SEEK cycle).
- A channel is therefore valid for dwell+1 cycles, followed by a 1-cycle gap.

stop:
- stop=1 in any non-IDLE state: next state is IDLE, indexValid<=0, no scanDone.
- stop and start asserted together in IDLE: stop wins and start is ignored.

Other rules:
- start while busy is ignored.
- Changes to chanMask/dwellCycles/oneShot during a scan have no effect until the next start.
- A single-bit mask in continuous mode revisits the same index, still with a 1-cycle SEEK gap.
- dwellCycles = 2^DWELL_W-1 gives 2^DWELL_W valid cycles; the counter never wraps within a dwell.
- scanDone never asserts for more than one consecutive cycle.

Test Plan:
- Reset check: hold rstN=0 for 3 cycles with start=1 -> index=0, indexValid=0, busy=0, scanDone=0 throughout; no scan begins.
- One-shot timing: mask=16'h0005, dwell=2, oneShot=1, start pulsed in cycle 0 -> cycle 1 SEEK (busy=1, valid=0); cycles 2-4 index=0, valid=1; cycle 5 gap; cycles 6-8 index=2, valid=1; cycle 9 busy=0, valid=0, scanDone=1; cycle 10 scanDone=0.
- Continuous wrap: mask=16'h8001, dwell=0, oneShot=0 -> index sequence 0,gap,15,gap,0,gap,15..., each channel valid 1 cycle; scanDone=1 exactly in each gap following index 15.
- Stop mid-dwell, then restart: mask=16'hFFFF, dwell=5, stop asserted in the 3rd valid cycle of index 4 -> next cycle busy=0, valid=0, scanDone=0, index holds 4; start then restarts at index 0.
- Empty mask and ignored inputs: start with mask=0 -> busy stays 0, scanDone=1 for one cycle. During a scan of mask=16'h0003, drive mask=16'hFFFF and start=1 -> visits only 0 and 1.
- Max dwell: DWELL_W=8, dwell=255, mask=16'h0010, oneShot=1 -> index=4 valid for exactly 256 cycles, then scanDone=1.
